// File: rtl/refresh_scheduler.sv
// refresh_scheduler: banks one auto-refresh debt every INTERVAL enabled clocks and hands it to the SDRAM sequencer via req/ack/done.
// Latency: debt rises on the wrap edge, ref_req follows one edge later; an ack raises ref_busy on the same edge.
// Backpressure: unserviced debt accumulates, saturates at MAX_DEBT and sets sticky overflow; REFRESH_BURST_EN chains refreshes with no idle cycle.
module refresh_scheduler #(
    parameter int CNT_W      = 8,
    parameter int INTERVAL   = 195,
    parameter int DEBT_W     = 4,
    parameter int MAX_DEBT   = 8,
    parameter int URGENT_THR = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              ref_ack,
    input  logic              ref_done,
    output logic              ref_req,
    output logic              ref_busy,
    output logic              ref_urgent,
    output logic              overflow,
    output logic [DEBT_W-1:0] debt,
    output logic [CNT_W-1:0]  tick_cnt
);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(INTERVAL - 1);
    localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(MAX_DEBT);
    localparam logic [DEBT_W-1:0] DEBT_URG = DEBT_W'(URGENT_THR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t            state;
    logic              tick;
    logic              accept;
    logic              sat_hit;
    logic [DEBT_W-1:0] debt_next;

    // A tick is the last count of a period while enabled; an accept is an ack seen in REQ only.
    assign tick   = en && (tick_cnt == CNT_LAST);
    assign accept = (state == REQ) && ref_ack;

    // Next debt: a tick and an accept on the same edge cancel; a tick at saturation only flags overflow.
    always_comb begin
        debt_next = debt;
        sat_hit   = 1'b0;
        if (tick && !accept) begin
            if (debt == DEBT_MAX) begin
                sat_hit = 1'b1;
            end else begin
                debt_next = debt + 1'b1;
            end
        end else if (accept && !tick && (debt != '0)) begin
            debt_next = debt - 1'b1;
        end
    end

    // Interval counter wraps at INTERVAL-1, never at the natural counter width.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (en) begin
            tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + 1'b1;
        end
    end

    // Debt register with urgency derived from the post-edge value and a sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            debt       <= '0;
            ref_urgent <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            debt       <= debt_next;
            ref_urgent <= (debt_next >= DEBT_URG);
            if (sat_hit) begin
                overflow <= 1'b1;
            end
        end
    end

    // Handshake FSM with registered Moore outputs: IDLE -> REQ -> BUSY -> IDLE (or straight to REQ in burst mode).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            ref_req  <= 1'b0;
            ref_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (debt != '0) begin
                        state   <= REQ;
                        ref_req <= 1'b1;
                    end
                end
                REQ: begin
                    // An ack wins over a simultaneous done; done is meaningless before BUSY.
                    if (ref_ack) begin
                        state    <= BUSY;
                        ref_req  <= 1'b0;
                        ref_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (ref_done) begin
`ifdef REFRESH_BURST_EN
                        if (debt != '0) begin
                            state    <= REQ;
                            ref_req  <= 1'b1;
                            ref_busy <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            ref_busy <= 1'b0;
                        end
`else
                        state    <= IDLE;
                        ref_busy <= 1'b0;
`endif
                    end
                end
                default: begin
                    state    <= IDLE;
                    ref_req  <= 1'b0;
                    ref_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
